pipe_ctrl_chain: RTL and testbench



---
 rtl/pipe_ctrl_chain.sv | 78 +++++++
 tb/tb_pipe_ctrl_chain.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl_chain.sv
// pipe_ctrl_chain: parametrised pipeline control-word carrier with stall, bubble, NOP select and flush.
// Optional macro PIPE_CTRL_PERF_EN adds the retired_cnt and bubble_cnt counters.
module pipe_ctrl_chain #(
  parameter int STAGES = 4,
  parameter int CW = 24,
  parameter int STALL_STAGE = 1,
  parameter logic [STAGES*CW-1:0] KEEP_MASKS = '1
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic [CW-1:0]        ctrl_in,
  input  logic                 valid_in,
  input  logic                 LE,
  input  logic                 S,
  input  logic [STAGES-1:0]    flush,
  output logic [STAGES*CW-1:0] stage_ctrl,
  output logic [STAGES-1:0]    stage_valid,
  output logic                 retire,
  output logic                 empty,
  output logic [15:0]          stall_cycles
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0]          retired_cnt,
  output logic [31:0]          bubble_cnt
`endif
);
  if (STAGES < 2 || STALL_STAGE < 1 || STALL_STAGE > STAGES - 1) begin : g_bad_param
    $error("pipe_ctrl_chain: illegal STAGES/STALL_STAGE");
  end
  logic [CW-1:0]     ctrl_q [STAGES];
  logic [CW-1:0]     ctrl_d [STAGES];
  logic [STAGES-1:0] valid_q, valid_d;
  for (genvar g = 0; g < STAGES; g++) begin : g_st
    logic [CW-1:0] src_c;
    logic          src_v, hold, bub;
    if (g == 0) begin : g_in
      assign src_c = valid_in ? ctrl_in : '0;
      assign src_v = valid_in;
    end else begin : g_mid
      assign src_c = ctrl_q[g-1];
      assign src_v = valid_q[g-1];
    end
    // Flush beats the stall hold; the stall hold beats NOP select on stage 0.
    assign hold = !flush[g] && !LE && (g < STALL_STAGE);
    assign bub  = flush[g] || (!LE && g == STALL_STAGE) || (g == 0 && S);
    assign ctrl_d[g]  = hold ? ctrl_q[g] : bub ? '0 : src_c & KEEP_MASKS[g*CW +: CW];
    assign valid_d[g] = hold ? valid_q[g] : !bub && src_v;
    assign stage_ctrl[g*CW +: CW] = ctrl_q[g];
  end
  assign stage_valid = valid_q;
  assign empty = ~|valid_q;
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      ctrl_q       <= '{default: '0};
      valid_q      <= '0;
      retire       <= 1'b0;
      stall_cycles <= '0;
    end else begin
      ctrl_q  <= ctrl_d;
      valid_q <= valid_d;
      retire  <= valid_q[STAGES-1] && !flush[STAGES-1];
      if (!LE && stall_cycles != 16'hFFFF) stall_cycles <= stall_cycles + 16'd1;
    end
  end
`ifdef PIPE_CTRL_PERF_EN
  logic bubble0;
  assign bubble0 = (flush[0] || LE) && !valid_d[0];
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      retired_cnt <= '0;
      bubble_cnt  <= '0;
    end else begin
      if (retire && ~&retired_cnt) retired_cnt <= retired_cnt + 32'd1;
      if (bubble0 && ~&bubble_cnt) bubble_cnt <= bubble_cnt + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_pipe_ctrl_chain.sv
// tb_pipe_ctrl_chain: directed self-checking bench for pipe_ctrl_chain (stage 3 keep-mask 24'h000003).
module tb_pipe_ctrl_chain;
  logic        Clk = 1'b0;
  logic        Rst = 1'b0;
  logic [23:0] ctrl_in = '0;
  logic        valid_in = 1'b0;
  logic        LE = 1'b1;
  logic        S = 1'b0;
  logic [3:0]  flush = '0;
  logic [95:0] stage_ctrl;
  logic [3:0]  stage_valid;
  logic        retire, empty;
  logic [15:0] stall_cycles;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] retired_cnt, bubble_cnt, bub_base;
`endif
  int checks = 0;
  int errors = 0;
  pipe_ctrl_chain #(
    .STAGES(4), .CW(24), .STALL_STAGE(1),
    .KEEP_MASKS({24'h000003, {3{24'hFFFFFF}}})
  ) dut (
    .Clk(Clk), .Rst(Rst), .ctrl_in(ctrl_in), .valid_in(valid_in), .LE(LE), .S(S),
    .flush(flush), .stage_ctrl(stage_ctrl), .stage_valid(stage_valid), .retire(retire),
    .empty(empty), .stall_cycles(stall_cycles)
`ifdef PIPE_CTRL_PERF_EN
    , .retired_cnt(retired_cnt), .bubble_cnt(bubble_cnt)
`endif
  );
  always #5 Clk = ~Clk;
  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask
  function automatic logic [23:0] sl(input int i);
    return stage_ctrl[i*24 +: 24];
  endfunction
  initial begin
    ctrl_in = 24'hA5A5A5;
    valid_in = 1'b1;
    #2;
    chk("rst_valid", 96'(stage_valid), 96'h0);
    chk("rst_ctrl", stage_ctrl, 96'h0);
    chk("rst_empty", 96'(empty), 96'h1);
    chk("rst_stall", 96'(stall_cycles), 96'h0);
`ifdef PIPE_CTRL_PERF_EN
    chk("rst_bubcnt", 96'(bubble_cnt), 96'h0);
`endif
    #1 Rst = 1'b1;
    // fill
    tick();
    chk("fill1_valid", 96'(stage_valid), 96'h1);
    chk("fill1_empty", 96'(empty), 96'h0);
    chk("fill1_s0", 96'(sl(0)), 96'hA5A5A5);
    tick();
    chk("fill2_valid", 96'(stage_valid), 96'h3);
    tick();
    chk("fill3_valid", 96'(stage_valid), 96'h7);
    tick();
    chk("fill4_valid", 96'(stage_valid), 96'hF);
    chk("fill4_retire", 96'(retire), 96'h0);
    chk("fill4_s3", 96'(sl(3)), 96'h000001);
    // masking
    ctrl_in = 24'hFFFFFF;
    tick();
    chk("fill5_retire", 96'(retire), 96'h1);
    chk("mask_s0", 96'(sl(0)), 96'hFFFFFF);
    tick(); tick(); tick();
    chk("mask_s3", 96'(sl(3)), 96'h000003);
    chk("mask_s0b", 96'(sl(0)), 96'hFFFFFF);
    // stall
    ctrl_in = 24'h123456;
    tick();
    LE = 1'b0;
    tick();
    chk("stall1_s0", 96'(sl(0)), 96'h123456);
    chk("stall1_s1", 96'(sl(1)), 96'h0);
    chk("stall1_valid", 96'(stage_valid), 96'hD);
    chk("stall1_s3", 96'(sl(3)), 96'h000003);
    tick(); tick();
    chk("stall3_valid", 96'(stage_valid), 96'h1);
    chk("stall3_s0", 96'(sl(0)), 96'h123456);
    chk("stall3_cnt", 96'(stall_cycles), 96'd3);
    chk("stall3_retire", 96'(retire), 96'h1);
    LE = 1'b1;
    tick();
    chk("unstall_s1", 96'(sl(1)), 96'h123456);
    chk("unstall_valid", 96'(stage_valid), 96'h3);
    chk("unstall_cnt", 96'(stall_cycles), 96'd3);
    chk("unstall_retire", 96'(retire), 96'h0);
    // NOP select
`ifdef PIPE_CTRL_PERF_EN
    bub_base = bubble_cnt;
`endif
    S = 1'b1;
    ctrl_in = 24'h0ABCDE;
    tick();
    chk("nop1_valid", 96'(stage_valid), 96'h6);
    chk("nop1_s0", 96'(sl(0)), 96'h0);
    tick();
    chk("nop2_valid", 96'(stage_valid), 96'hC);
`ifdef PIPE_CTRL_PERF_EN
    chk("nop_bubcnt", 96'(bubble_cnt - bub_base), 96'd2);
`endif
    S = 1'b0;
    valid_in = 1'b0;
    tick();
    chk("drain1_retire", 96'(retire), 96'h1);
    tick();
    chk("drain2_retire", 96'(retire), 96'h1);
    chk("drain2_empty", 96'(empty), 96'h1);
    tick();
    chk("nop_retire", 96'(retire), 96'h0);
    // flush
    valid_in = 1'b1;
    ctrl_in = 24'h00000F;
    tick(); tick(); tick(); tick();
    chk("refill_valid", 96'(stage_valid), 96'hF);
    flush = 4'b1000;
    tick();
    chk("flush3_retire", 96'(retire), 96'h0);
    chk("flush3_valid", 96'(stage_valid), 96'h7);
    flush = 4'b0001;
    LE = 1'b0;
    tick();
    chk("flush0_s0", 96'(sl(0)), 96'h0);
    chk("flush0_valid", 96'(stage_valid), 96'hC);
    chk("flush0_cnt", 96'(stall_cycles), 96'd4);
    // async reset between edges
    flush = 4'b0000;
    #3 Rst = 1'b0;
    #1;
    chk("arst_valid", 96'(stage_valid), 96'h0);
    chk("arst_ctrl", stage_ctrl, 96'h0);
    chk("arst_retire", 96'(retire), 96'h0);
    chk("arst_stall", 96'(stall_cycles), 96'h0);
    chk("arst_empty", 96'(empty), 96'h1);
    #2 Rst = 1'b1;
    LE = 1'b1;
    ctrl_in = 24'h000077;
    tick();
    chk("post_valid", 96'(stage_valid), 96'h1);
    chk("post_s0", 96'(sl(0)), 96'h000077);
    chk("post_stall", 96'(stall_cycles), 96'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
